// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  // Frame receiver states, advanced on filtered ps2_clk falling edges.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Scan-code prefixes: extended key and key release.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // 2 ms at 100 MHz between clock edges inside a frame.
  localparam int TIMEOUT_CYC_DEF = 200000;
  // Consecutive equal samples needed before a ps2_clk level change is believed.
  localparam int FILT_LEN_DEF    = 8;

endpackage

// File: rtl/ps2_key_ctrl_rx.sv
// PS/2 frame receiver: synchronizers, ps2_clk glitch filter, frame FSM and
// inter-edge timeout. Emits one rx_valid pulse per good frame and one rx_err
// pulse per discarded frame.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic       clk_100m,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int             FW        = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0]  FILT_LAST = FW'(FILT_LEN - 1);
  localparam int             TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYC - 1);

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt, r_clk_filt_d;
  logic [FW-1:0] r_filt_cnt;
  logic [TW-1:0] r_to_cnt;
  ps2_state_t    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [7:0]    r_rx_byte;
  logic          r_rx_valid, r_rx_err;
  logic          w_fall_det;

  // Two-flop synchronizers; reset to the idle-high line level.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Accept a new ps2_clk level only after FILT_LEN consecutive samples of it.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall_det = r_clk_filt_d & ~r_clk_filt;

  // Frame FSM with timeout; a stalled frame is abandoned as an error.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_to_cnt   <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      if (r_state == IDLE || w_fall_det) r_to_cnt <= '0;
      else                               r_to_cnt <= r_to_cnt + 1'b1;

      if (r_state != IDLE && !w_fall_det && r_to_cnt == TO_LAST) begin
        r_state  <= IDLE;
        r_rx_err <= 1'b1;
      end else if (w_fall_det) begin
        case (r_state)
          IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end
          end
          DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= STOP;
          end
          STOP: begin
            // Odd parity over data+parity and a high stop bit, else discard.
            if ((^{r_shift, r_par}) && r_dat_s2) begin
              r_rx_byte  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_rx_err <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rx_byte  = r_rx_byte;
  assign rx_valid = r_rx_valid;
  assign rx_err   = r_rx_err;

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard controller: scan-code decoder (E0/F0 prefixes), key-event
// FIFO and last-make-code register on top of the frame receiver.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic       clk_100m,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_byte,
  output logic       key_ext,
  output logic [7:0] ps2_byte,
  output logic       frame_err,
  output logic       overflow
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    w_rx_byte;
  logic          w_rx_valid, w_rx_err;
  logic          r_ext_flag, r_brk_flag;
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_ps2_byte;
  logic          r_overflow;
  logic          w_push_req, w_push, w_pop, w_full;
  logic [8:0]    w_head;

  ps2_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .FILT_LEN   (FILT_LEN)
  ) u_rx (
    .clk_100m(clk_100m),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (w_rx_byte),
    .rx_valid(w_rx_valid),
    .rx_err  (w_rx_err)
  );

  // A make code is any non-prefix byte not preceded by a break prefix.
  assign w_push_req = w_rx_valid && (w_rx_byte != PS2_EXT) &&
                      (w_rx_byte != PS2_BRK) && !r_brk_flag;
  assign w_full     = (r_count == DEPTH_C);
  assign w_pop      = key_valid && key_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_head     = r_mem[r_rd_ptr];

  // Prefix tracking; any receive error abandons a partial sequence.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
    end else if (w_rx_err) begin
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
    end else if (w_rx_valid) begin
      if (w_rx_byte == PS2_EXT) begin
        r_ext_flag <= 1'b1;
      end else if (w_rx_byte == PS2_BRK) begin
        r_brk_flag <= 1'b1;
      end else begin
        r_ext_flag <= 1'b0;
        r_brk_flag <= 1'b0;
      end
    end
  end

  // Event FIFO storage, pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push_req && w_full && !w_pop;
      if (w_push) begin
        r_mem[r_wr_ptr] <= {r_ext_flag, w_rx_byte};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Last accepted make code, updated only by an event that entered the FIFO.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)      r_ps2_byte <= '0;
    else if (w_push) r_ps2_byte <= w_rx_byte;
  end

  assign key_valid = (r_count != '0);
  assign key_byte  = w_head[7:0];
  assign key_ext   = w_head[8];
  assign ps2_byte  = r_ps2_byte;
  assign frame_err = w_rx_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a shortened timeout and filter.
module tb_ps2_key_ctrl;

  localparam int TO = 400;

  logic       clk_100m = 1'b0;
  logic       rst_n, ps2_clk, ps2_data, key_ready;
  logic       key_valid, key_ext, frame_err, overflow;
  logic [7:0] key_byte, ps2_byte;

  always #5 clk_100m = ~clk_100m;

  ps2_key_ctrl #(
    .FIFO_DEPTH (4),
    .TIMEOUT_CYC(TO),
    .FILT_LEN   (4)
  ) dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_ready(key_ready),
    .key_valid(key_valid),
    .key_byte (key_byte),
    .key_ext  (key_ext),
    .ps2_byte (ps2_byte),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Event monitor, sampled on the falling clock edge.
  int         cyc = 0;
  int         last_fall = 0, lat = -1, kv_cyc = 0;
  int         ferr_n = 0, ferr_cyc = 0, ovf_n = 0, pop_n = 0;
  logic       prev_kv = 1'b0;
  logic [8:0] last_pop = '0;
  logic [7:0] rise_ps2 = '0;

  always @(posedge clk_100m) cyc <= cyc + 1;

  always @(negedge clk_100m) begin
    if (dut.u_rx.w_fall_det) last_fall <= cyc;
    if (key_valid && !prev_kv) begin
      lat      <= cyc - last_fall;
      rise_ps2 <= ps2_byte;
    end
    if (key_valid) kv_cyc <= kv_cyc + 1;
    if (frame_err) begin
      ferr_n   <= ferr_n + 1;
      ferr_cyc <= cyc;
    end
    if (overflow) ovf_n <= ovf_n + 1;
    if (key_valid && key_ready) begin
      pop_n    <= pop_n + 1;
      last_pop <= {key_ext, key_byte};
    end
    prev_kv <= key_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100m);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(20);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(bad_par ? (^b) : ~(^b));
    send_bit(1'b1);
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i]);
    ps2_data = 1'b1;
  endtask

  int pop0, kv0, ferr0, ovf0, fall_stamp;
  logic [7:0] ovf_codes [5];

  initial begin
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; key_ready = 1'b0;
    ovf_codes[0] = 8'h16; ovf_codes[1] = 8'h1E; ovf_codes[2] = 8'h26;
    ovf_codes[3] = 8'h25; ovf_codes[4] = 8'h2E;

    // Reset state
    tick(4);
    @(negedge clk_100m);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_byte",  key_byte,  0);
    check("rst_key_ext",   key_ext,   0);
    check("rst_ps2_byte",  ps2_byte,  0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow",  overflow,  0);
    tick(1);
    rst_n = 1'b1;
    tick(10);

    // Single make code 1C with consumer ready
    key_ready = 1'b1;
    pop0 = pop_n; kv0 = kv_cyc; ferr0 = ferr_n;
    send_frame(8'h1C, 1'b0);
    check("m1c_pops",     pop_n - pop0, 1);
    check("m1c_event",    last_pop, 9'h01C);
    check("m1c_ps2_byte", ps2_byte, 8'h1C);
    check("m1c_ps2_rise", rise_ps2, 8'h1C);
    check("m1c_latency",  lat, 2);
    check("m1c_kv_cycles", kv_cyc - kv0, 1);
    check("m1c_ferr",     ferr_n - ferr0, 0);

    // Extended make then extended break: one event only
    pop0 = pop_n; ferr0 = ferr_n;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("ext_pops",     pop_n - pop0, 1);
    check("ext_event",    last_pop, 9'h175);
    check("ext_ps2_byte", ps2_byte, 8'h75);
    check("ext_ferr",     ferr_n - ferr0, 0);

    // Parity error
    pop0 = pop_n; ferr0 = ferr_n; kv0 = kv_cyc;
    send_frame(8'h1C, 1'b1);
    check("par_ferr",     ferr_n - ferr0, 1);
    check("par_pops",     pop_n - pop0, 0);
    check("par_kv_cycles", kv_cyc - kv0, 0);
    check("par_ps2_byte", ps2_byte, 8'h75);

    // Stalled frame times out, next frame is clean
    ferr0 = ferr_n; pop0 = pop_n;
    send_partial(8'hA5, 4);
    tick(TO + 60);
    fall_stamp = last_fall;
    check("to_ferr",   ferr_n - ferr0, 1);
    check("to_window", ((ferr_cyc - fall_stamp) >= TO) && ((ferr_cyc - fall_stamp) <= TO + 2), 1);
    send_frame(8'h29, 1'b0);
    check("to_next_pops",  pop_n - pop0, 1);
    check("to_next_event", last_pop, 9'h029);

    // Fill the FIFO with the consumer stalled; fifth event overflows
    key_ready = 1'b0;
    ovf0 = ovf_n;
    for (int i = 0; i < 4; i++) send_frame(ovf_codes[i], 1'b0);
    check("full_ovf_none", ovf_n - ovf0, 0);
    send_frame(ovf_codes[4], 1'b0);
    check("full_ovf_one",  ovf_n - ovf0, 1);
    check("full_ps2_byte", ps2_byte, 8'h25);
    check("full_valid",    key_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_100m);
      check($sformatf("pop%0d_byte", i), key_byte, ovf_codes[i]);
      check($sformatf("pop%0d_ext", i),  key_ext, 0);
      #1 key_ready = 1'b1;
      @(posedge clk_100m);
      #1 key_ready = 1'b0;
    end
    @(negedge clk_100m);
    check("drained_valid", key_valid, 0);

    // Reset in the middle of a frame
    key_ready = 1'b1;
    send_partial(8'h3C, 6);
    rst_n = 1'b0;
    @(negedge clk_100m);
    check("mid_rst_key_valid", key_valid, 0);
    check("mid_rst_key_byte",  key_byte, 0);
    check("mid_rst_ps2_byte",  ps2_byte, 0);
    check("mid_rst_ferr",      frame_err, 0);
    tick(3);
    rst_n = 1'b1;
    tick(10);
    pop0 = pop_n; ferr0 = ferr_n;
    send_frame(8'h45, 1'b0);
    check("post_rst_pops",  pop_n - pop0, 1);
    check("post_rst_event", last_pop, 9'h045);
    check("post_rst_ferr",  ferr_n - ferr0, 0);
    check("post_rst_ps2",   ps2_byte, 8'h45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: key-event FIFO entries, power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYC, default 200000: idle clocks (2 ms at 100 MHz) tolerated between PS/2 clock edges inside a frame.
REQ-003 Parameter FILT_LEN, default 8: consecutive equal samples required to accept a ps2_clk level change.
REQ-004 clk_100m  in  1  system clock, 100 MHz.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ps2_clk  in  1  raw PS/2 device clock, asynchronous, idle high.
REQ-007 ps2_data  in  1  raw PS/2 device data, asynchronous, idle high.
REQ-008 key_ready  in  1  consumer accepts the FIFO head this cycle.
REQ-009 key_valid  out  1  FIFO non-empty; key_ext/key_byte are valid.
REQ-010 key_byte  out  8  make code at the FIFO head.
REQ-011 key_ext  out  1  FIFO head was E0-prefixed.
REQ-012 ps2_byte  out  8  last accepted make code, held for the display path.
REQ-013 frame_err  out  1  one-cycle pulse on a discarded frame.
REQ-014 overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-015 The block shall pass ps2_clk and ps2_data through two-flop synchronizers, then filter ps2_clk with FILT_LEN.
REQ-016 The block shall sample ps2_data on each filtered ps2_clk falling edge (fall_det, one-cycle strobe).
REQ-017 The frame FSM shall use states IDLE, DATA, PARITY, STOP, driven by fall_det.
- IDLE: a start bit of 0 goes to DATA; a start bit of 1 is ignored and stays in IDLE.
- DATA: 8 bits, LSB first, then PARITY.
- PARITY: then STOP.
REQ-018 Frame checks at STOP:
- Odd parity shall hold over the 8 data bits plus the parity bit.
- Stop bit shall be 1.
- Either failure: frame_err pulses, byte discarded, FSM returns to IDLE.
REQ-019 Timeout: in any state other than IDLE, TIMEOUT_CYC clocks without fall_det shall return the FSM to IDLE and pulse frame_err.
REQ-020 Decoder:
- Byte 8'hE0 sets ext_flag.
- Byte 8'hF0 sets brk_flag.
- Any other byte with brk_flag set is discarded, and both flags clear.
- Any other byte with brk_flag clear pushes {ext_flag, byte}, and both flags clear.
REQ-021 A frame_err or timeout shall clear ext_flag and brk_flag.
REQ-022 Latency: with the FIFO empty, key_valid shall rise exactly 2 cycles after the stop-bit fall_det; ps2_byte updates in the same cycle.
REQ-023 ps2_byte shall update only on a successful push and otherwise hold its value.
REQ-024 FIFO pop shall occur when key_valid and key_ready are both high; key_ready while empty has no effect.
REQ-025 FIFO full:
- Push without pop: the new event is dropped, overflow pulses, ps2_byte is unchanged.
- Push with pop in the same cycle: both occur and no overflow.
REQ-026 FIFO pointers shall wrap modulo FIFO_DEPTH; occupancy shall use a log2(FIFO_DEPTH)+1-bit count.
REQ-027 key_byte and key_ext shall be stable while key_valid is high and key_ready is low.

Reset
REQ-028 On rst_n low the block shall clear:
- all outputs to 0;
- FSM to IDLE;
- FIFO to empty;
- ext_flag and brk_flag;
- timeout counter.
REQ-029 On rst_n low the synchronizer and filter state shall reset to 1 (idle line level).
REQ-030 A reset mid-frame shall discard the partial frame; the next recognised start is a fresh 0 sample in IDLE.

Structure
REQ-031 Package ps2_pkg shall hold:
- the FSM state enum;
- constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
- default values of TIMEOUT_CYC and FILT_LEN.
REQ-032 Sub-module ps2_rx shall contain:
- synchronizers, filter, frame FSM and timeout;
- outputs rx_byte[7:0], rx_valid (pulse) and rx_err (pulse).
REQ-033 The decoder, FIFO and ps2_byte register shall reside in ps2_key_ctrl.

Verification
REQ-034 Frame 8'h1C with correct parity, key_ready=1 -> key_valid 1 cycle, key_byte=8'h1C, key_ext=0, ps2_byte=8'h1C.
REQ-035 Sequence E0,75 then E0,F0,75 -> exactly one event: key_ext=1, key_byte=8'h75; the break sequence pushes nothing.
REQ-036 Frame 8'h1C with even parity -> frame_err one pulse, key_valid stays 0, ps2_byte unchanged.
REQ-037 Frame stopped after 4 data bits -> frame_err after TIMEOUT_CYC clocks; next good frame 8'h29 -> key_byte=8'h29.
REQ-038 key_ready=0, 5 make codes 8'h16,8'h1E,8'h26,8'h25,8'h2E -> overflow on the 5th only; pops return 16,1E,26,25 in order.
REQ-039 rst_n pulsed low after 6 data bits of a frame -> all outputs 0; next clean frame 8'h45 -> key_byte=8'h45.
